// File: rtl/button_reader_pkg.sv
// Shared constants for the push-button conditioning path: clock rate, default cycle counts, FSM encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package button_reader_pkg;

   // SB_HFOSC output frequency; default cycle counts are derived from it.
   localparam int CLK_HZ              = 48_000_000;
   localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;   // 10 ms
   localparam int DEF_LONG_CYCLES     = CLK_HZ;         // 1 s

   // FSM encodings, kept as plain localparams so other blocks and probes can
   // decode the state without pulling in the enum type.
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DEB_DOWN  = 3'd1;
   localparam logic [2:0] ST_PRESSED   = 3'd2;
   localparam logic [2:0] ST_LONG_HELD = 3'd3;
   localparam logic [2:0] ST_DEB_UP    = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      DEB_DOWN  = ST_DEB_DOWN,
      PRESSED   = ST_PRESSED,
      LONG_HELD = ST_LONG_HELD,
      DEB_UP    = ST_DEB_UP
   } state_t;

   // Unpressed pad level for a given polarity; used as the synchroniser reset value.
   function automatic logic idle_pad_level(input logic active_low);
      return active_low;
   endfunction

endpackage

// File: rtl/button_reader_if.sv
// Bundle of the raw pad input and the conditioned button events.
// Latency: n/a (wiring only).
// Backpressure: none; events are single-cycle strobes the consumer must sample.
interface button_reader_if;

   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic short_press;
   logic long_press;
   logic hold_active;

   // master: the button conditioner itself
   modport master (
      input  btn_in,
      output btn_level,
      output press_pulse,
      output release_pulse,
      output short_press,
      output long_press,
      output hold_active
   );

   // slave: the pad side driving btn_in and the logic consuming the events
   modport slave (
      output btn_in,
      input  btn_level,
      input  press_pulse,
      input  release_pulse,
      input  short_press,
      input  long_press,
      input  hold_active
   );

endinterface

// File: rtl/button_reader_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad level, reset to a chosen idle value.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
module button_reader_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;
   logic stable;

   // Two-stage capture; reset to the idle level so reset release never looks like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= RST_VAL;
         stable <= RST_VAL;
      end else begin
         meta   <= d;
         stable <= meta;
      end
   end

   assign q = stable;

endmodule

// File: rtl/button_reader.sv
// Push-button conditioner: sync, polarity normalise, debounce, short/long press classification.
// Latency: press/release strobe DEBOUNCE_CYCLES+3 clk after a clean pad change; long_press LONG_CYCLES after press.
// Backpressure: none; all events are registered one-cycle strobes.
module button_reader
   import button_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   button_reader_if.master bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   logic          sync_q;
   logic          p;
   state_t        state;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_next;
   logic          long_flag;

   logic          btn_level_q;
   logic          press_pulse_q;
   logic          release_pulse_q;
   logic          short_press_q;
   logic          long_press_q;
   logic          hold_active_q;

   button_reader_sync_2ff #(
      .RST_VAL (idle_pad_level(ACTIVE_LOW))
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_in),
      .q   (sync_q)
   );

   // Pressed = 1 regardless of pad polarity.
   assign p = ACTIVE_LOW ? ~sync_q : sync_q;

   // Hold counter saturates so a very long hold never wraps back into a short press.
   assign hold_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HW'(1);

   // Debounce / press-classification FSM with registered strobes and levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         deb_cnt         <= '0;
         hold_cnt        <= '0;
         long_flag       <= 1'b0;
         btn_level_q     <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         short_press_q   <= 1'b0;
         long_press_q    <= 1'b0;
         hold_active_q   <= 1'b0;
      end else begin
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         short_press_q   <= 1'b0;
         long_press_q    <= 1'b0;

         case (state)
            IDLE: begin
               if (p) begin
                  state   <= DEB_DOWN;
                  deb_cnt <= '0;
               end
            end

            DEB_DOWN: begin
               if (!p) begin
                  state <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  state         <= PRESSED;
                  btn_level_q   <= 1'b1;
                  press_pulse_q <= 1'b1;
                  hold_cnt      <= '0;
                  long_flag     <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + DW'(1);
               end
            end

            PRESSED: begin
               hold_cnt <= hold_next;
               // Reaching the long threshold wins over a release seen in the same cycle.
               if (hold_cnt == HOLD_LAST) begin
                  state         <= LONG_HELD;
                  long_press_q  <= 1'b1;
                  long_flag     <= 1'b1;
                  hold_active_q <= 1'b1;
               end else if (!p) begin
                  state   <= DEB_UP;
                  deb_cnt <= '0;
               end
            end

            LONG_HELD: begin
               hold_cnt <= hold_next;
               if (!p) begin
                  state   <= DEB_UP;
                  deb_cnt <= '0;
               end
            end

            DEB_UP: begin
               // Hold time keeps accruing while a release is still unconfirmed.
               hold_cnt <= hold_next;
               if (p) begin
                  state <= long_flag ? LONG_HELD : PRESSED;
               end else if (deb_cnt == DEB_LAST) begin
                  state           <= IDLE;
                  btn_level_q     <= 1'b0;
                  release_pulse_q <= 1'b1;
                  short_press_q   <= ~long_flag;
                  hold_active_q   <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + DW'(1);
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.btn_level     = btn_level_q;
   assign bus.press_pulse   = press_pulse_q;
   assign bus.release_pulse = release_pulse_q;
   assign bus.short_press   = short_press_q;
   assign bus.long_press    = long_press_q;
   assign bus.hold_active   = hold_active_q;

endmodule
